// File: rtl/bit_seq_detector.sv
// -----------------------------------------------------------------------------
// bit_seq_detector
//
// Purpose:
//   This block sits downstream of a 1-bit enabled flop stage. It takes the
//   registered serial bit and the enable that qualifies it. It keeps a history
//   of the last PAT_WIDTH accepted bits and raises a one-cycle match pulse each
//   time that history equals PATTERN. Matches are counted in a saturating
//   counter that can be read as status.
//
// Parameters:
//   PAT_WIDTH  pattern length in bits (2..16)
//   PATTERN    target pattern; MSB is the oldest accepted bit
//   CNT_WIDTH  width of the saturating match counter
//
// Ports:
//   clk        in   1          system clock, rising edge
//   reset      in   1          synchronous, active-high reset
//   d_in       in   1          serial data bit (q of the upstream flop)
//   en         in   1          bit-valid qualifier; bit accepted on clk with en=1
//   cnt_clr    in   1          synchronous clear of match_cnt only
//   hist       out  PAT_WIDTH  last PAT_WIDTH accepted bits, newest in bit 0
//   fill_full  out  1          at least PAT_WIDTH bits accepted since the
//                              history was last emptied
//   match      out  1          one-cycle pulse, pattern detected
//   match_cnt  out  CNT_WIDTH  number of matches, saturating
//
// Optional build macro:
//   SEQ_NONOVERLAP_EN  When defined, detection is non-overlapping. The edge
//                      that sets match also empties the history and the fill
//                      count, so a new match needs PAT_WIDTH fresh bits. When
//                      undefined, detection overlaps and the fill count only
//                      returns to zero on reset.
// -----------------------------------------------------------------------------
module bit_seq_detector #(
  parameter int unsigned          PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1011,
  parameter int unsigned          CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_in,
  input  logic                 en,
  input  logic                 cnt_clr,
  output logic [PAT_WIDTH-1:0] hist,
  output logic                 fill_full,
  output logic                 match,
  output logic [CNT_WIDTH-1:0] match_cnt
);

  // The fill counter has to hold every value from 0 through PAT_WIDTH.
  localparam int unsigned          FILL_W   = $clog2(PAT_WIDTH + 1);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // FILLING: fewer than PAT_WIDTH bits are held, so the history is not yet
  //          trustworthy and cannot produce a match.
  // RUN:     the history is full and every accepted bit is a candidate match.
  typedef enum logic {
    FILLING = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [FILL_W-1:0]      fill_reg, fill_next;
  logic [PAT_WIDTH-1:0]   hist_reg, hist_next;
  logic [PAT_WIDTH-1:0]   hist_shift;
  logic                   fill_full_reg, fill_full_next;
  logic                   match_reg, match_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                   hit;

  // ---------------------------------------------------------------------------
  // History shift: bit 0 takes the new bit and every older bit moves up one
  // place. The oldest bit (MSB) is discarded.
  // ---------------------------------------------------------------------------
  assign hist_shift[0] = d_in;

  generate
    for (genvar gi = 1; gi < PAT_WIDTH; gi++) begin : g_shift
      assign hist_shift[gi] = hist_reg[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FILLING;
      fill_reg      <= '0;
      hist_reg      <= '0;
      fill_full_reg <= 1'b0;
      match_reg     <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      fill_reg      <= fill_next;
      hist_reg      <= hist_next;
      fill_full_reg <= fill_full_next;
      match_reg     <= match_next;
      cnt_reg       <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    hist_next  = hist_reg;
    hit        = 1'b0;
    cnt_next   = cnt_reg;

    if (en) begin
      hist_next = hist_shift;

      case (state_reg)
        FILLING: begin
          fill_next = fill_reg + 1'b1;
          if (fill_next == FILL_MAX) begin
            state_next = RUN;
          end
        end
        RUN: begin
          // The count saturates once the history is full.
          fill_next = FILL_MAX;
        end
        default: begin
          state_next = FILLING;
          fill_next  = '0;
        end
      endcase

      // The match is decided on the bit being accepted now, not on the
      // registered history. This lets the pulse appear in the cycle right
      // after the final pattern bit. Gating on the fill count stops a stale
      // all-zero history from matching patterns such as 0001 right after
      // reset.
      hit = (fill_next == FILL_MAX) && (hist_next == PATTERN);
    end

`ifdef SEQ_NONOVERLAP_EN
    // Non-overlapping mode: a match uses up the bits that formed it.
    if (hit) begin
      hist_next  = '0;
      fill_next  = '0;
      state_next = FILLING;
    end
`endif

    match_next     = hit;
    fill_full_next = (fill_next == FILL_MAX);

    // A clear takes priority over an increment on the same edge. Without a
    // clear, the count stops at all-ones and does not wrap.
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (hit && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all come straight from registers
  // ---------------------------------------------------------------------------
  assign hist      = hist_reg;
  assign fill_full = fill_full_reg;
  assign match     = match_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_bit_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_bit_seq_detector
//
// Three detector instances share one stimulus stream:
//   u_a  default parameters (PATTERN 1011, 8-bit counter)
//   u_b  PATTERN 0001 (early-fill guard)
//   u_c  PATTERN 1011, 2-bit counter (saturation)
// Each step drives the inputs, runs a behavioural model of every instance and
// pushes the expected outputs onto a queue. After the clock edge the entries
// are popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_bit_seq_detector;

  logic clk = 1'b0;
  logic reset, d_in, en, cnt_clr;

  logic [3:0] hist_a, hist_b, hist_c;
  logic       ff_a, ff_b, ff_c;
  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  bit_seq_detector #(.PAT_WIDTH(4), .PATTERN(4'b1011), .CNT_WIDTH(8)) u_a (
    .clk(clk), .reset(reset), .d_in(d_in), .en(en), .cnt_clr(cnt_clr),
    .hist(hist_a), .fill_full(ff_a), .match(match_a), .match_cnt(cnt_a));

  bit_seq_detector #(.PAT_WIDTH(4), .PATTERN(4'b0001), .CNT_WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .d_in(d_in), .en(en), .cnt_clr(cnt_clr),
    .hist(hist_b), .fill_full(ff_b), .match(match_b), .match_cnt(cnt_b));

  bit_seq_detector #(.PAT_WIDTH(4), .PATTERN(4'b1011), .CNT_WIDTH(2)) u_c (
    .clk(clk), .reset(reset), .d_in(d_in), .en(en), .cnt_clr(cnt_clr),
    .hist(hist_c), .fill_full(ff_c), .match(match_c), .match_cnt(cnt_c));

  typedef struct {
    logic [3:0] hist;
    logic       ff;
    logic       m;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model state, one entry per instance.
  logic [3:0] m_hist[3];
  int         m_fill[3];
  logic       m_match[3];
  int         m_cnt[3];
  logic [3:0] pats[3] = '{4'b1011, 4'b0001, 4'b1011};
  int         cmax[3] = '{255, 255, 3};
  string      names[3] = '{"a", "b", "c"};

  int pass_cnt  = 0;
  int check_cnt = 0;
  int step_no   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step(input logic d, input logic e, input logic c, input logic r);
    exp_t x;
    d_in    = d;
    en      = e;
    cnt_clr = c;
    reset   = r;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_hist[i]  = 4'b0;
        m_fill[i]  = 0;
        m_match[i] = 1'b0;
        m_cnt[i]   = 0;
      end else begin
        m_match[i] = 1'b0;
        if (e) begin
          m_hist[i] = {m_hist[i][2:0], d};
          if (m_fill[i] < 4) m_fill[i]++;
          m_match[i] = (m_fill[i] == 4) && (m_hist[i] == pats[i]);
        end
`ifdef SEQ_NONOVERLAP_EN
        if (m_match[i]) begin
          m_hist[i] = 4'b0;
          m_fill[i] = 0;
        end
`endif
        if (c) m_cnt[i] = 0;
        else if (m_match[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
      x.hist = m_hist[i];
      x.ff   = (m_fill[i] == 4);
      x.m    = m_match[i];
      x.cnt  = 8'(m_cnt[i]);
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    step_no++;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] oh;
      logic       of, om;
      logic [7:0] oc;
      x = exp_q.pop_front();
      case (i)
        0: begin oh = hist_a; of = ff_a; om = match_a; oc = cnt_a; end
        1: begin oh = hist_b; of = ff_b; om = match_b; oc = cnt_b; end
        default: begin oh = hist_c; of = ff_c; om = match_c; oc = {6'b0, cnt_c}; end
      endcase
      check($sformatf("s%0d_%s_hist", step_no, names[i]), 16'(oh), 16'(x.hist));
      check($sformatf("s%0d_%s_full", step_no, names[i]), 16'(of), 16'(x.ff));
      check($sformatf("s%0d_%s_match", step_no, names[i]), 16'(om), 16'(x.m));
      check($sformatf("s%0d_%s_cnt", step_no, names[i]), 16'(oc), 16'(x.cnt));
    end
    $display("step %0d rst=%0b en=%0b d=%0b clr=%0b | a:h=%b m=%0b c=%0d b:h=%b m=%0b c:c=%0d",
             step_no, r, e, d, c, hist_a, match_a, cnt_a, hist_b, match_b, cnt_c);
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      logic [15:0] t;
      t = v;
      step(t[k], 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; d_in = 1'b1; cnt_clr = 1'b0;

    // The reset is held for two cycles with en and d_in high.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_hist", 16'(hist_a), 16'h0);
    check("reset_full", 16'(ff_a), 16'h0);
    check("reset_match", 16'(match_a), 16'h0);
    check("reset_cnt", 16'(cnt_a), 16'h0);

    // Basic match on the sequence 1011.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(16'b1011, 4);
    check("basic_match", 16'(match_a), 16'h1);
    check("basic_cnt", 16'(cnt_a), 16'h1);
    check("basic_hist", 16'(hist_a), 16'hB);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("basic_pulse_end", 16'(match_a), 16'h0);

    // Overlap: the sequence 1011011 matches twice by default.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(16'b1011011, 7);
`ifdef SEQ_NONOVERLAP_EN
    check("overlap_cnt", 16'(cnt_a), 16'h1);
`else
    check("overlap_cnt", 16'(cnt_a), 16'h2);
`endif

    // Enable gaps: d_in toggles while en is low.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    begin
      logic [3:0] pat;
      pat = 4'b1011;
      for (int k = 3; k >= 0; k--) begin
        step(pat[k], 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) step(g[0], 1'b0, 1'b0, 1'b0);
      end
    end
    check("gap_cnt", 16'(cnt_a), 16'h1);

    // Early-fill guard for instance b (pattern 0001).
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("early_hist", 16'(hist_b), 16'h1);
    check("early_nomatch", 16'(match_b), 16'h0);
    bits(16'b0001, 4);
    check("early_late_match", 16'(match_b), 16'h1);

    // Counter saturation on instance c, then cnt_clr on the same edge as a match.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(16'b1011011011011011, 16);
`ifndef SEQ_NONOVERLAP_EN
    check("sat_cnt", 16'(cnt_c), 16'h3);
`endif
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_cnt", 16'(cnt_c), 16'h0);
`ifndef SEQ_NONOVERLAP_EN
    check("clr_match", 16'(match_c), 16'h1);
`endif

    // A reset in the middle of a sequence discards the partial pattern.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(16'b101, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("midreset_nomatch", 16'(match_a), 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
